muldiv_sched: RTL and testbench

- Execute-stage sequencer for the HI/LO multiply/divide resources.
- On a mult/div in EX it launches the fixed-latency multiplier or the iterative divider, and stalls EX until the result exists.
- It captures the result into holding registers and presents it until the instruction leaves EX.
- It cancels in-flight operations on flushE and sits beside the EX-stage control pipeline registers, feeding the hazard unit's stall logic.

---
 rtl/muldiv_pkg.sv | 11 +
 rtl/muldiv_sched.sv | 107 ++++++++++
 tb/tb_muldiv_sched.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared state encoding and sizing for the HI/LO multiply/divide sequencer
package muldiv_pkg;
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MUL_WAIT = 2'd1,
    DIV_WAIT = 2'd2,
    DONE     = 2'd3
  } state_e;
  localparam int MUL_LAT_DEFAULT = 2;
  localparam int CNT_W = 4;
endpackage

// File: rtl/muldiv_sched.sv
// muldiv_sched: EX-stage launch/stall/capture sequencer for the multiplier and iterative divider
module muldiv_sched
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int MUL_LAT = MUL_LAT_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ismultE,
  input  logic             signedmultE,
  input  logic             isdivE,
  input  logic             signeddivE,
  input  logic             flushE,
  input  logic             stall_otherE,
  input  logic [WIDTH-1:0] mul_hi,
  input  logic [WIDTH-1:0] mul_lo,
  input  logic             div_ready,
  input  logic [WIDTH-1:0] div_hi,
  input  logic [WIDTH-1:0] div_lo,
  output logic             mul_start,
  output logic             mul_signed,
  output logic             div_start,
  output logic             div_signed,
  output logic             div_cancel,
  output logic             stall_muldivE,
  output logic             muldiv_validE,
  output logic [WIDTH-1:0] hiE,
  output logic [WIDTH-1:0] loE,
  output logic             busy
);
  state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    hi_d = hi_q;
    lo_d = lo_q;
    mul_start = 1'b0;
    div_start = 1'b0;
    div_cancel = 1'b0;
    stall_muldivE = 1'b0;
    muldiv_validE = 1'b0;
    case (state_q)
      IDLE: begin
        if (!flushE && isdivE) begin
          div_start = 1'b1;
          stall_muldivE = 1'b1;
          state_d = DIV_WAIT;
        end else if (!flushE && ismultE) begin
          mul_start = 1'b1;
          stall_muldivE = 1'b1;
          cnt_d = CNT_W'(MUL_LAT - 1);
          state_d = MUL_WAIT;
        end
      end
      MUL_WAIT: begin
        if (flushE) state_d = IDLE;
        else if (cnt_q != '0) begin
          stall_muldivE = 1'b1;
          cnt_d = cnt_q - 1'b1;
        end else begin
          stall_muldivE = 1'b1;
          hi_d = mul_hi;
          lo_d = mul_lo;
          state_d = DONE;
        end
      end
      DIV_WAIT: begin
        if (flushE) begin
          div_cancel = 1'b1;
          state_d = IDLE;
        end else begin
          stall_muldivE = 1'b1;
          if (div_ready) begin
            hi_d = div_hi;
            lo_d = div_lo;
            state_d = DONE;
          end
        end
      end
      default: begin
        muldiv_validE = 1'b1;
        state_d = (flushE || !stall_otherE) ? IDLE : DONE;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end
  assign mul_signed = signedmultE;
  assign div_signed = signeddivE;
  assign hiE = hi_q;
  assign loE = lo_q;
  assign busy = state_q != IDLE;
endmodule

// File: tb/tb_muldiv_sched.sv
// tb_muldiv_sched: randomized transaction-level check of muldiv_sched against cycle-count rules
module tb_muldiv_sched;
  localparam int W = 32;
  localparam int MUL_LAT = 2;
  logic clk = 1'b0;
  logic rst, ismultE, signedmultE, isdivE, signeddivE, flushE, stall_otherE;
  logic [W-1:0] mul_hi, mul_lo, div_hi, div_lo, hiE, loE;
  logic div_ready, mul_start, mul_signed, div_start, div_signed, div_cancel;
  logic stall_muldivE, muldiv_validE, busy;
  logic [W-1:0] exp_hi, exp_lo;
  int n_chk = 0;
  int n_err = 0;
  always #5 clk = ~clk;
  muldiv_sched #(.WIDTH(W), .MUL_LAT(MUL_LAT)) dut (
    .clk(clk), .rst(rst), .ismultE(ismultE), .signedmultE(signedmultE),
    .isdivE(isdivE), .signeddivE(signeddivE), .flushE(flushE), .stall_otherE(stall_otherE),
    .mul_hi(mul_hi), .mul_lo(mul_lo), .div_ready(div_ready), .div_hi(div_hi), .div_lo(div_lo),
    .mul_start(mul_start), .mul_signed(mul_signed), .div_start(div_start), .div_signed(div_signed),
    .div_cancel(div_cancel), .stall_muldivE(stall_muldivE), .muldiv_validE(muldiv_validE),
    .hiE(hiE), .loE(loE), .busy(busy)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic noise();
    mul_hi = W'($urandom);
    mul_lo = W'($urandom);
    div_hi = W'($urandom);
    div_lo = W'($urandom);
    div_ready = 1'($urandom);
    signedmultE = 1'($urandom);
    signeddivE = 1'($urandom);
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      noise();
      ismultE = 1'b0;
      isdivE = 1'b0;
      flushE = 1'($urandom);
      stall_otherE = 1'($urandom);
      @(negedge clk);
      chk("idle_busy", busy, 0);
      chk("idle_stall", stall_muldivE, 0);
      chk("idle_start", {mul_start, div_start, div_cancel, muldiv_validE}, 0);
      chk("idle_hi", hiE, exp_hi);
      chk("idle_lo", loE, exp_lo);
    end
  endtask
  // kind: 0 mult, 1 div, 2 both opcodes; j = div_ready cycle; flush_at < 0 means no flush
  task automatic run_op(input int kind, input int j, input int hold, input int flush_at,
                        input logic [W-1:0] hv, input logic [W-1:0] lv);
    bit is_div = kind != 0;
    int done_cyc = is_div ? j + 1 : MUL_LAT + 1;
    bit fin = 0;
    int k = 0;
    while (!fin) begin
      @(posedge clk);
      #1;
      noise();
      ismultE = kind != 1;
      isdivE = kind != 0;
      flushE = k == flush_at;
      stall_otherE = k >= done_cyc ? (k - done_cyc < hold) : 1'($urandom);
      if (!is_div && k == MUL_LAT) begin
        mul_hi = hv;
        mul_lo = lv;
      end
      if (is_div && k >= 1 && k <= j) div_ready = k == j;
      if (is_div && k == j) begin
        div_hi = hv;
        div_lo = lv;
      end
      @(negedge clk);
      if (k == 0) begin
        chk("start_busy", busy, 0);
        chk("mul_signed", mul_start ? mul_signed : signedmultE, signedmultE);
        chk("div_signed", div_start ? div_signed : signeddivE, signeddivE);
      end
      if (k == done_cyc && flush_at < 0) begin
        exp_hi = hv;
        exp_lo = lv;
      end
      if (k == flush_at) begin
        chk("flush_stall", stall_muldivE, 0);
        chk("flush_cancel", div_cancel, is_div);
        chk("flush_valid", muldiv_validE, 0);
        fin = 1;
      end else if (k < done_cyc) begin
        chk("wait_stall", stall_muldivE, 1);
        chk("wait_mul_start", mul_start, k == 0 && !is_div);
        chk("wait_div_start", div_start, k == 0 && is_div);
        chk("wait_cancel", div_cancel, 0);
        chk("wait_valid", muldiv_validE, 0);
      end else begin
        chk("done_stall", stall_muldivE, 0);
        chk("done_valid", muldiv_validE, 1);
        chk("done_pulses", {mul_start, div_start, div_cancel}, 0);
        fin = k - done_cyc >= hold;
      end
      chk("hi", hiE, exp_hi);
      chk("lo", loE, exp_lo);
      k++;
      if (k > 200 && !fin) begin
        chk("timeout", 1, 0);
        fin = 1;
      end
    end
  endtask
  task automatic reset_mid(input bit is_div);
    @(posedge clk);
    #1;
    noise();
    div_ready = 1'b0;
    ismultE = !is_div;
    isdivE = is_div;
    flushE = 1'b0;
    stall_otherE = 1'b0;
    @(negedge clk);
    chk("rst_launch", {mul_start, div_start}, is_div ? 2'b01 : 2'b10);
    @(posedge clk);
    #1;
    rst = 1'b1;
    div_ready = 1'b0;
    @(negedge clk);
    chk("rst_cycle_cancel", div_cancel, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    ismultE = 1'b0;
    isdivE = 1'b0;
    exp_hi = '0;
    exp_lo = '0;
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_outs", {mul_start, div_start, div_cancel, stall_muldivE, muldiv_validE}, 0);
    chk("rst_hi", hiE, 0);
    chk("rst_lo", loE, 0);
  endtask
  initial begin
    rst = 1'b1;
    ismultE = 1'b0;
    isdivE = 1'b0;
    flushE = 1'b0;
    stall_otherE = 1'b0;
    noise();
    exp_hi = '0;
    exp_lo = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_outs", {mul_start, div_start, div_cancel, stall_muldivE, muldiv_validE}, 0);
    chk("reset_hi", hiE, 0);
    #1;
    rst = 1'b0;
    run_op(0, 0, 0, -1, 32'h1, 32'hFFFF_FFFE);
    idle(1);
    run_op(1, 33, 0, -1, 32'd3, 32'd7);
    idle(1);
    run_op(1, 40, 0, 10, 32'hDEAD, 32'hBEEF);
    idle(3);
    run_op(0, 0, 4, -1, 32'h1234_5678, 32'h9ABC_DEF0);
    idle(1);
    run_op(0, 0, 0, MUL_LAT, 32'h5555, 32'hAAAA);
    idle(1);
    reset_mid(0);
    reset_mid(1);
    run_op(2, 5, 1, -1, 32'hCAFE, 32'hF00D);
    run_op(1, 3, 0, -1, 32'h11, 32'h22);
    run_op(0, 0, 0, -1, 32'h33, 32'h44);
    for (int i = 0; i < 40; i++) begin
      int kind = $urandom_range(0, 2);
      int j = $urandom_range(1, 40);
      int dc = kind == 0 ? MUL_LAT + 1 : j + 1;
      int fa = $urandom_range(0, 4) == 0 ? $urandom_range(1, dc - 1) : -1;
      run_op(kind, j, $urandom_range(0, 3), fa, W'($urandom), W'($urandom));
      idle($urandom_range(0, 2));
    end
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
